matrix_slot_manager: RTL
========================

Name: matrix_slot_manager

Overview:
Allocates and tracks matrix storage slots in the shared 256-word matrix RAM for the input, generator and compute writers. Hands a writer a base address on request (the input path's addr-ready handshake), marks the slot valid on commit, and resolves (m,n,index) lookups to a base address for operand selection and display. Enforces a per-dimension capacity, evicting the least-recently-committed matrix when that capacity or the RAM is full.

Parameters:
NUM_SLOTS, 8, number of slots; slot s occupies words s*SLOT_WORDS .. s*SLOT_WORDS+SLOT_WORDS-1
SLOT_WORDS, 25, words per slot (max 5x5)
MAX_PER_DIM, 2, max valid matrices sharing one (m,n)
MAX_DIM, 5, largest legal m or n

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
alloc_req  in  1  level; request slot for alloc_m x alloc_n; held until alloc_ack
alloc_m  in  3  rows 1..5
alloc_n  in  3  cols 1..5
alloc_ack  out  1  one-cycle pulse; alloc_base/alloc_slot valid same cycle and held until next ack
alloc_base  out  8  base word address of granted slot
alloc_slot  out  3  granted slot index
alloc_err  out  1  one-cycle pulse instead of ack when dims are illegal
commit  in  1  pulse; granted slot now holds a complete matrix
abort  in  1  pulse; discard the pending grant
lookup_req  in  1  pulse; query (lookup_m, lookup_n, lookup_idx)
lookup_m  in  3  rows
lookup_n  in  3  cols
lookup_idx  in  2  0 = most recent matrix with those dims, 1 = next older
lookup_done  out  1  one-cycle pulse
lookup_hit  out  1  valid with lookup_done
lookup_base  out  8  base address on hit, else 0
dim_count  out  2  number of valid slots matching the lookup dims, valid with lookup_done
total_valid  out  4  number of valid slots
busy  out  1  high in any state other than IDLE or PENDING

Behaviour:
- Reset: all outputs 0; every slot invalid; every slot age = its index; state IDLE.
- Per-slot table: valid, m, n, age (rank 0 = newest .. NUM_SLOTS-1 = oldest). Ages always form a permutation.
- States: IDLE, ALLOC_SCAN, ALLOC_GRANT, PENDING, LOOK_SCAN, LOOK_DONE.
- IDLE: alloc_req has priority over lookup_req when both are asserted in the same cycle. A lookup_req pulse that loses arbitration is dropped.
- Allocation dims check: m or n equal to 0 or greater than MAX_DIM -> alloc_err pulse the next cycle, return to IDLE, table unchanged.
- ALLOC_SCAN: visits one slot per cycle for NUM_SLOTS cycles and tracks three things:
  - same-dims count and the oldest same-dims slot;
  - the lowest-index invalid slot;
  - the oldest slot overall.
- Victim selection:
  - same-dims count >= MAX_PER_DIM -> oldest same-dims slot;
  - else an invalid slot exists -> lowest-index invalid slot;
  - else -> oldest slot overall.
- ALLOC_GRANT: drive alloc_ack for one cycle. alloc_base = slot*SLOT_WORDS, computed as shift-add in 8 bits; maximum is 175. Clear the victim's valid bit immediately. Go to PENDING.
  - Allocation latency: request to ack = NUM_SLOTS + 2 cycles.
- PENDING (busy=0): waits for commit or abort; lookups are serviced meanwhile and return to PENDING.
  - commit: slot valid=1, stores m,n. Slot age -> 0. Every slot whose age was below the slot's old age increments by 1. Go to IDLE.
  - abort: slot stays invalid, ages unchanged. Go to IDLE.
  - commit and abort in the same cycle -> abort wins.
  - alloc_req while PENDING is ignored until commit or abort.
- LOOK_SCAN: one slot per cycle; counts valid slots matching (m,n). Selects the matching slot with rank lookup_idx among matches ordered by age ascending.
- LOOK_DONE: one-cycle pulse with results, then back to the originating state (IDLE or PENDING).
  - Lookup latency: NUM_SLOTS + 1 cycles.
  - idx >= count -> hit=0, base=0.
- total_valid: updated combinationally from the valid bits (popcount).
- Asynchronous reset mid-operation returns to the reset state immediately; the pending grant is lost.

Optional Feature:
SLOT_CLEAR_EN:
- When defined: adds input port clear_all (pulse). Honoured in IDLE or PENDING; invalidates all slots, resets ages to index order, drops any pending grant, returns to IDLE the next cycle.
- When undefined: no port, no logic.

Decomposition:
- Package matrix_pkg: SLOT_WORDS, NUM_SLOTS, MAX_DIM, MAX_PER_DIM, state encodings, and the slot-entry field widths (dimension 3 bits, age 3 bits).
- One sub-module, slot_age_tracker: holds the age permutation and applies the promote-to-newest update on commit.

Test Plan:
- Reset, alloc 2x3, commit; lookup (2,3,0) -> ack after 10 cycles, base 0; hit=1, base 0, dim_count 1, total_valid 1.
- Three allocs of 3x3 with commits -> bases 0, 25, then 0 again (oldest same-dims evicted); lookup idx0 base 0, idx1 base 25.
- Fill all 8 slots with distinct dims, then alloc 1x1 -> slot 0 (oldest) reused, base 0; total_valid 8 after commit.
- Alloc 4x4 then abort -> lookup (4,4,0) hit=0, dim_count 0; alloc_m=6 -> alloc_err pulse, no ack.
- alloc_req and lookup_req in the same cycle -> allocation proceeds, lookup_done never pulses; lookup issued in PENDING completes and returns to PENDING.
- With SLOT_CLEAR_EN: three commits then clear_all -> total_valid 0; next alloc grants slot 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, FSM states and address helpers for the matrix slot manager
package matrix_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SLOT_WORDS = 25;
  localparam int DIM_W = 3;
  localparam int AGE_W = 3;
  localparam int SLOT_W = 3;
  localparam logic [DIM_W-1:0] MAX_DIM = 3'd5;
  localparam logic [3:0] MAX_PER_DIM = 4'd2;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(NUM_SLOTS - 1);
  typedef enum logic [2:0] {IDLE, ALLOC_SCAN, ALLOC_GRANT, PENDING, LOOK_SCAN, LOOK_DONE} state_t;
  function automatic logic [7:0] slot_base(input logic [SLOT_W-1:0] s);
    return {1'b0, s, 4'b0} + {2'b0, s, 3'b0} + {5'b0, s};
  endfunction
  function automatic logic [NUM_SLOTS-1:0][AGE_W-1:0] init_ages();
    for (int j = 0; j < NUM_SLOTS; j++) init_ages[j] = AGE_W'(j);
  endfunction
endpackage

// File: rtl/slot_age_tracker.sv
// slot_age_tracker: age permutation per slot, promoting a committed slot to newest
module slot_age_tracker
  import matrix_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            promote,
  input  logic [SLOT_W-1:0]               slot,
  output logic [NUM_SLOTS-1:0][AGE_W-1:0] age
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age <= init_ages();
    else if (clr) age <= init_ages();
    else if (promote)
      for (int j = 0; j < NUM_SLOTS; j++)
        age[j] <= SLOT_W'(j) == slot ? '0 : age[j] < age[slot] ? age[j] + 1'b1 : age[j];
endmodule

// File: rtl/matrix_slot_manager.sv
// matrix_slot_manager: matrix RAM slot allocator and (m,n,idx) lookup; SLOT_CLEAR_EN adds clear_all
module matrix_slot_manager
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
`ifdef SLOT_CLEAR_EN
  input  logic              clear_all,
`endif
  input  logic              alloc_req,
  input  logic [DIM_W-1:0]  alloc_m,
  input  logic [DIM_W-1:0]  alloc_n,
  output logic              alloc_ack,
  output logic [7:0]        alloc_base,
  output logic [SLOT_W-1:0] alloc_slot,
  output logic              alloc_err,
  input  logic              commit,
  input  logic              abort,
  input  logic              lookup_req,
  input  logic [DIM_W-1:0]  lookup_m,
  input  logic [DIM_W-1:0]  lookup_n,
  input  logic [1:0]        lookup_idx,
  output logic              lookup_done,
  output logic              lookup_hit,
  output logic [7:0]        lookup_base,
  output logic [1:0]        dim_count,
  output logic [3:0]        total_valid,
  output logic              busy
);
  state_t state, ret;
  logic [NUM_SLOTS-1:0] valid;
  logic [NUM_SLOTS-1:0][DIM_W-1:0] sm, sn;
  logic [NUM_SLOTS-1:0][AGE_W-1:0] age;
  logic [DIM_W-1:0] am, an, lm, ln;
  logic [1:0] li;
  logic [SLOT_W-1:0] idx, old_same, free_slot, old_all, victim;
  logic [AGE_W-1:0] old_same_age;
  logic [3:0] cnt;
  logic [2:0] rank;
  logic [7:0] lk_base;
  logic has_free, lk_hit, clr, promote, look_go, dims_bad, a_same, l_match, l_sel;
`ifdef SLOT_CLEAR_EN
  assign clr = clear_all && (state == IDLE || state == PENDING);
`else
  assign clr = 1'b0;
`endif
  assign dims_bad = alloc_m == '0 || alloc_m > MAX_DIM || alloc_n == '0 || alloc_n > MAX_DIM;
  assign a_same = valid[idx] && sm[idx] == am && sn[idx] == an;
  assign l_match = valid[idx] && sm[idx] == lm && sn[idx] == ln;
  assign l_sel = l_match && rank == {1'b0, li};
  assign victim = cnt >= MAX_PER_DIM ? old_same : has_free ? free_slot : old_all;
  assign promote = !clr && state == PENDING && commit && !abort;
  assign look_go = !clr && lookup_req && ((state == IDLE && !alloc_req) || (state == PENDING && !commit && !abort));
  assign total_valid = 4'($countones(valid));
  assign busy = state != IDLE && state != PENDING;
  always_comb begin
    rank = '0;
    for (int j = 0; j < NUM_SLOTS; j++)
      rank += (valid[j] && sm[j] == lm && sn[j] == ln && age[j] < age[idx]) ? 3'd1 : 3'd0;
  end
  slot_age_tracker u_age (
    .clk(clk), .rst_n(rst_n), .clr(clr), .promote(promote), .slot(alloc_slot), .age(age)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ret <= IDLE;
      valid <= '0;
      sm <= '0;
      sn <= '0;
      {am, an, lm, ln, li, idx, cnt} <= '0;
      {old_same, old_same_age, free_slot, old_all, has_free} <= '0;
      {lk_hit, lk_base} <= '0;
      {alloc_ack, alloc_base, alloc_slot, alloc_err} <= '0;
      {lookup_done, lookup_hit, lookup_base, dim_count} <= '0;
    end else begin
      alloc_ack <= 1'b0;
      alloc_err <= 1'b0;
      lookup_done <= 1'b0;
      if (look_go) begin
        {lm, ln, li} <= {lookup_m, lookup_n, lookup_idx};
        ret <= state;
        idx <= '0;
        cnt <= '0;
        lk_hit <= 1'b0;
        lk_base <= '0;
      end
      if (clr) begin
        valid <= '0;
        state <= IDLE;
      end else
        case (state)
          IDLE:
            if (alloc_req && dims_bad) alloc_err <= 1'b1;
            else if (alloc_req) begin
              {am, an} <= {alloc_m, alloc_n};
              idx <= '0;
              cnt <= '0;
              has_free <= 1'b0;
              state <= ALLOC_SCAN;
            end else if (look_go) state <= LOOK_SCAN;
          ALLOC_SCAN: begin
            if (a_same) begin
              cnt <= cnt + 4'd1;
              if (cnt == '0 || age[idx] > old_same_age) {old_same, old_same_age} <= {idx, age[idx]};
            end
            if (!valid[idx] && !has_free) {has_free, free_slot} <= {1'b1, idx};
            if (age[idx] == LAST) old_all <= idx;
            idx <= idx + 1'b1;
            if (idx == LAST) state <= ALLOC_GRANT;
          end
          ALLOC_GRANT: begin
            alloc_ack <= 1'b1;
            alloc_slot <= victim;
            alloc_base <= slot_base(victim);
            valid[victim] <= 1'b0;
            state <= PENDING;
          end
          PENDING:
            if (abort) state <= IDLE;
            else if (commit) begin
              valid[alloc_slot] <= 1'b1;
              sm[alloc_slot] <= am;
              sn[alloc_slot] <= an;
              state <= IDLE;
            end else if (look_go) state <= LOOK_SCAN;
          LOOK_SCAN: begin
            if (l_match) cnt <= cnt + 4'd1;
            if (l_sel) {lk_hit, lk_base} <= {1'b1, slot_base(idx)};
            idx <= idx + 1'b1;
            if (idx == LAST) begin
              lookup_done <= 1'b1;
              lookup_hit <= lk_hit || l_sel;
              lookup_base <= l_sel ? slot_base(idx) : lk_base;
              dim_count <= 2'(cnt + {3'b0, l_match});
              state <= LOOK_DONE;
            end
          end
          LOOK_DONE: state <= ret;
          default: state <= IDLE;
        endcase
    end
endmodule
